// File: rtl/fb_pkg.sv
// Shared sizing, FSM state type and pixel-write request for the double-buffered frame buffer.
package fb_pkg;
   localparam int FB_ROWS = 32;
   localparam int FB_COLS = 64;
   localparam int FB_SCAN = 16;
   localparam int FB_RW   = $clog2(FB_ROWS);
   localparam int FB_CW   = $clog2(FB_COLS);

   typedef enum logic {IDLE, CLEAR} fb_state_t;

   typedef struct packed {
      logic             en;
      logic [FB_RW-1:0] row;
      logic [FB_CW-1:0] col;
      logic             on;
   } fb_px_t;
endpackage

// File: rtl/fb_bank.sv
// One 32x64 register bank: whole-row clear, single-pixel write, two combinational row reads.
module fb_bank
   import fb_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               clr_en,
   input  logic [FB_RW-1:0]   clr_row,
   input  fb_px_t             px,
   input  logic [FB_RW-1:0]   rd_row_a,
   output logic [FB_COLS-1:0] rd_data_a,
   input  logic [FB_RW-1:0]   rd_row_b,
   output logic [FB_COLS-1:0] rd_data_b
);
   logic [FB_ROWS-1:0][FB_COLS-1:0] mem;

   // Clear and pixel write never coincide at the top level; clear wins if they ever do.
   always_ff @(posedge clk) begin
      if (rst)
         mem <= '0;
      else if (clr_en)
         mem[clr_row] <= '0;
      else if (px.en)
         mem[px.row][px.col] <= px.on;
   end

   assign rd_data_a = mem[rd_row_a];
   assign rd_data_b = mem[rd_row_b];
endmodule

// File: rtl/frame_buffer.sv
// Double-buffered 32x64 display memory: display scans the front bank, game logic writes/clears
// the back bank, and a requested swap is deferred to the next frame boundary.
module frame_buffer
   import fb_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [4:0]         raddr,
   input  logic               ren,
   output logic [FB_COLS-1:0] Hline,
   output logic [FB_COLS-1:0] Lline,
   input  logic               px_valid,
   output logic               px_ready,
   input  logic [FB_RW-1:0]   px_row,
   input  logic [FB_CW-1:0]   px_col,
   input  logic               px_on,
   input  logic               clr_req,
   input  logic               swap_req,
   output logic               swap_done,
   output logic               busy
);
   fb_state_t          state, state_nxt;
   logic [FB_RW-1:0]   row_cnt;
   logic               bank_sel;
   logic               swap_pending;
   logic               clr_en;
   logic               boundary, do_swap;
   fb_px_t             px_wr, px_b0, px_b1;
   logic [FB_COLS-1:0] h0, l0, h1, l1;
   logic [FB_RW-1:0]   rd_hi, rd_lo;
   logic               unused_raddr;

   // Only 16 scan rows exist; the top address bit is don't-care.
   assign unused_raddr = raddr[4];

   // State register and clear row counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         row_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (state == CLEAR)
            row_cnt <= row_cnt + 1'b1;
         else if (clr_req)
            row_cnt <= '0;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (clr_req) state_nxt = CLEAR;
         CLEAR:   if (row_cnt == FB_RW'(FB_ROWS-1)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      px_ready = (state == IDLE) && !clr_req;
      clr_en   = (state == CLEAR);
   end

   assign boundary = ren && (raddr[3:0] == 4'hF);
   assign do_swap  = boundary && swap_pending && (state == IDLE);
   assign busy     = (state == CLEAR) || swap_pending;

   always_ff @(posedge clk) begin
      if (rst) begin
         bank_sel     <= 1'b0;
         swap_pending <= 1'b0;
         swap_done    <= 1'b0;
      end else begin
         swap_done <= do_swap;
         if (do_swap) begin
            bank_sel     <= ~bank_sel;
            swap_pending <= 1'b0;
         end else if (swap_req) begin
            swap_pending <= 1'b1;
         end
      end
   end

   // Writes and clears always target the bank that is not being displayed (pre-swap select).
   assign px_wr = '{en: px_valid && px_ready, row: px_row, col: px_col, on: px_on};
   always_comb begin
      px_b0    = px_wr;
      px_b1    = px_wr;
      px_b0.en = px_wr.en && bank_sel;
      px_b1.en = px_wr.en && !bank_sel;
   end

   assign rd_hi = {1'b0, raddr[3:0]};
   assign rd_lo = {1'b1, raddr[3:0]};

   fb_bank u_bank0 (
      .clk(clk), .rst(rst),
      .clr_en(clr_en && bank_sel), .clr_row(row_cnt), .px(px_b0),
      .rd_row_a(rd_hi), .rd_data_a(h0), .rd_row_b(rd_lo), .rd_data_b(l0)
   );

   fb_bank u_bank1 (
      .clk(clk), .rst(rst),
      .clr_en(clr_en && !bank_sel), .clr_row(row_cnt), .px(px_b1),
      .rd_row_a(rd_hi), .rd_data_a(h1), .rd_row_b(rd_lo), .rd_data_b(l1)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         Hline <= '0;
         Lline <= '0;
      end else if (ren) begin
         Hline <= bank_sel ? h1 : h0;
         Lline <= bank_sel ? l1 : l0;
      end
   end
endmodule

// File: tb/tb_frame_buffer.sv
// Cycle-level scoreboard bench for frame_buffer: a behavioural bank model predicts every read.
module tb_frame_buffer;
   logic        clk, rst;
   logic [4:0]  raddr;
   logic        ren;
   logic [63:0] Hline, Lline;
   logic        px_valid, px_ready;
   logic [4:0]  px_row;
   logic [5:0]  px_col;
   logic        px_on, clr_req, swap_req, swap_done, busy;

   frame_buffer dut (
      .clk(clk), .rst(rst), .raddr(raddr), .ren(ren), .Hline(Hline), .Lline(Lline),
      .px_valid(px_valid), .px_ready(px_ready), .px_row(px_row), .px_col(px_col),
      .px_on(px_on), .clr_req(clr_req), .swap_req(swap_req), .swap_done(swap_done),
      .busy(busy)
   );

   typedef struct {
      logic [63:0] h;
      logic [63:0] l;
      logic        sd;
   } exp_t;

   exp_t        q[$];
   logic [63:0] mb[2][32];
   logic [63:0] mh, ml;
   int          msel, mpend, mstate, mcnt;
   int          errors = 0, checks = 0, sd_seen = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "watchdog");
   end

   task automatic model_reset();
      for (int b = 0; b < 2; b++)
         for (int r = 0; r < 32; r++) mb[b][r] = '0;
      mh = '0; ml = '0; msel = 0; mpend = 0; mstate = 0; mcnt = 0;
   endtask

   // One clock: predict, push expectation, take the edge, pop and compare.
   task automatic tick();
      exp_t e;
      logic rdy, bnd, dsw, mbusy;
      int   bk;
      #1;
      rdy   = (mstate == 0) && !clr_req;
      mbusy = (mstate == 1) || (mpend != 0);
      if (!rst) begin
         checks++;
         if (px_ready !== rdy) begin
            errors++; $display("FAIL px_ready: got %b want %b", px_ready, rdy);
         end
         checks++;
         if (busy !== mbusy) begin
            errors++; $display("FAIL busy: got %b want %b", busy, mbusy);
         end
      end
      bnd = ren && (raddr[3:0] == 4'hF);
      dsw = bnd && (mpend != 0) && (mstate == 0);
      if (rst) begin
         model_reset();
         e.h = '0; e.l = '0; e.sd = 1'b0;
      end else begin
         if (ren) begin
            mh = mb[msel][{1'b0, raddr[3:0]}];
            ml = mb[msel][{1'b1, raddr[3:0]}];
         end
         e.h = mh; e.l = ml; e.sd = dsw;
         bk = 1 - msel;
         if (px_valid && rdy) mb[bk][px_row][px_col] = px_on;
         if (mstate == 1) begin
            mb[bk][mcnt] = '0;
            if (mcnt == 31) mstate = 0;
            mcnt = (mcnt + 1) % 32;
         end else if (clr_req) begin
            mstate = 1; mcnt = 0;
         end
         if (dsw) begin
            msel = 1 - msel; mpend = 0;
         end else if (swap_req) mpend = 1;
      end
      q.push_back(e);
      @(posedge clk); #1;
      clr_req = 1'b0; swap_req = 1'b0;
      e = q.pop_front();
      checks++;
      if (Hline !== e.h) begin
         errors++; $display("FAIL Hline: got %h want %h", Hline, e.h);
      end
      checks++;
      if (Lline !== e.l) begin
         errors++; $display("FAIL Lline: got %h want %h", Lline, e.l);
      end
      checks++;
      if (swap_done !== e.sd) begin
         errors++; $display("FAIL swap_done: got %b want %b", swap_done, e.sd);
      end
      if (swap_done === 1'b1) sd_seen++;
   endtask

   task automatic write_px(input int r, input int c, input logic on);
      px_valid = 1'b1; px_row = 5'(r); px_col = 6'(c); px_on = on;
      tick();
      px_valid = 1'b0;
   endtask

   task automatic scan();
      for (int r = 0; r < 16; r++) begin
         ren = 1'b1; raddr = {1'($urandom_range(0, 1)), 4'(r)};
         tick();
      end
      ren = 1'b0;
   endtask

   task automatic read_row(input int r);
      ren = 1'b1; raddr = {1'($urandom_range(0, 1)), 4'(r)};
      tick();
      ren = 1'b0;
   endtask

   task automatic do_swap();
      swap_req = 1'b1;
      tick();
      scan();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      checks++;
      if (Hline !== 64'h0 || Lline !== 64'h0) begin
         errors++; $display("FAIL reset_lines: got %h/%h want 0/0", Hline, Lline);
      end
      checks++;
      if (busy !== 1'b0 || swap_done !== 1'b0) begin
         errors++; $display("FAIL reset_flags: got busy=%b sd=%b want 0/0", busy, swap_done);
      end
      scan();
   endtask

   task automatic test_pixel_swap();
      write_px(3, 5, 1'b1);
      sd_seen = 0;
      do_swap();
      checks++;
      if (sd_seen != 1) begin
         errors++; $display("FAIL swap_count: got %0d want 1", sd_seen);
      end
      read_row(3);
      checks++;
      if (Hline !== 64'h20 || Lline !== 64'h0) begin
         errors++; $display("FAIL row3_after_swap: got %h/%h want 20/0", Hline, Lline);
      end
   endtask

   task automatic test_lower_half();
      write_px(19, 0, 1'b1);
      do_swap();
      read_row(3);
      checks++;
      if (Lline !== 64'h1 || Hline !== 64'h0) begin
         errors++; $display("FAIL row19: got H=%h L=%h want H=0 L=1", Hline, Lline);
      end
      do_swap();
      write_px(19, 0, 1'b0);
      do_swap();
      read_row(3);
      checks++;
      if (Lline !== 64'h0) begin
         errors++; $display("FAIL row19_restore: got %h want 0", Lline);
      end
   endtask

   task automatic test_clear();
      int          n;
      logic [63:0] want;
      for (int i = 0; i < 6; i++) write_px($urandom_range(0, 31), $urandom_range(0, 63), 1'b1);
      clr_req = 1'b1;
      px_valid = 1'b1; px_row = 5'd7; px_col = 6'd42; px_on = 1'b1;
      tick();
      n = 0;
      forever begin
         #1;
         if (px_ready === 1'b1 || n >= 100) break;
         if (n == 10) clr_req = 1'b1;
         tick();
         n++;
      end
      checks++;
      if (n != 32) begin
         errors++; $display("FAIL clear_len: got %0d want 32 cycles", n);
      end
      tick();
      px_valid = 1'b0;
      do_swap();
      scan();
      read_row(7);
      want = 64'd1 << 42;
      checks++;
      if (Hline !== want) begin
         errors++; $display("FAIL clear_pixel: got %h want %h", Hline, want);
      end
   endtask

   task automatic test_swap_during_clear();
      int first = -1;
      for (int i = 0; i < 10; i++) write_px($urandom_range(0, 31), $urandom_range(0, 63), 1'b1);
      clr_req = 1'b1;
      tick();
      for (int i = 1; i <= 80; i++) begin
         if (i == 1) swap_req = 1'b1;
         ren = 1'b1; raddr = {1'($urandom_range(0, 1)), 4'(i % 16)};
         tick();
         if (swap_done === 1'b1 && first < 0) first = i;
      end
      ren = 1'b0;
      checks++;
      if (first != 47) begin
         errors++; $display("FAIL swap_after_clear: got cycle %0d want 47", first);
      end
      scan();
   endtask

   task automatic test_reset_mid_clear();
      clr_req = 1'b1;
      tick();
      swap_req = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL busy_after_rst: got %b want 0", busy);
      end
      sd_seen = 0;
      scan();
      scan();
      checks++;
      if (sd_seen != 0) begin
         errors++; $display("FAIL swap_after_rst: got %0d pulses want 0", sd_seen);
      end
   endtask

   initial begin
      rst = 1'b1; ren = 1'b0; raddr = '0; px_valid = 1'b0; px_row = '0; px_col = '0;
      px_on = 1'b0; clr_req = 1'b0; swap_req = 1'b0;
      model_reset();
      @(posedge clk); #1;
      test_reset();
      test_pixel_swap();
      test_lower_half();
      test_clear();
      test_swap_during_clear();
      test_reset_mid_clear();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
